mgu_edge_scatter: RTL and testbench

Message Generation Unit. Sits downstream of the message processing unit and accepts activated-vertex records {prop, edge_index, edge_degree}. Walks the vertex's edge list in HBM, one 256-bit line per read, and emits one update message {dst vertex address, new value} per edge. It is the transmitter that feeds the processing unit's update/update_ready/update_resp receive port.

---
 rtl/mgu_pkg.sv | 58 +++++
 rtl/mgu_lane_select.sv | 28 ++
 rtl/mgu_edge_scatter.sv | 162 ++++++++++++++++
 tb/tb_mgu_edge_scatter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mgu_pkg.sv
// Shared types, constants and helpers for the message generation unit.
// Build with WEIGHTED_EDGE_EN for 64-bit {weight,dst} edges (SSSP); default is 32-bit dst-only edges (BFS).
package mgu_pkg;

    localparam int unsigned VPropWidth   = 32;
    localparam int unsigned EIndexWidth  = 32;
    localparam int unsigned EDegreeWidth = 32;
    localparam int unsigned AddrWidth    = 33;
    localparam int unsigned DataWidth    = 256;
    localparam int unsigned UpdateWidth  = AddrWidth + VPropWidth;
    localparam int unsigned MgudWidth    = VPropWidth + EIndexWidth + EDegreeWidth + 1;
    localparam int unsigned DstWidth     = 32;
    localparam int unsigned VertexShift  = 5;
    localparam int unsigned LineShift    = 5;

    localparam logic [AddrWidth-1:0] EdgeBase   = 33'h1_0000_0000;
    localparam logic [AddrWidth-1:0] VertexBase = 33'h0;

`ifdef WEIGHTED_EDGE_EN
    localparam int unsigned EdgeWidth = 64;
    localparam int unsigned LaneWidth = 2;
`else
    localparam int unsigned EdgeWidth = 32;
    localparam int unsigned LaneWidth = 3;
`endif
    localparam int unsigned Epl = DataWidth / EdgeWidth;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_READ_WAIT,
        S_EMIT,
        S_EMIT_ACK,
        S_EMIT_REL
    } state_e;

    // Activated-vertex record as presented on MGU_data; the MSB carries nothing.
    typedef struct packed {
        logic                    spare;
        logic [VPropWidth-1:0]   prop;
        logic [EIndexWidth-1:0]  edge_index;
        logic [EDegreeWidth-1:0] edge_degree;
    } mgu_rec_t;

    typedef struct packed {
        logic [AddrWidth-1:0]  addr;
        logic [VPropWidth-1:0] value;
    } update_t;

    function automatic logic [VPropWidth-1:0] sat_add(input logic [VPropWidth-1:0] a,
                                                      input logic [VPropWidth-1:0] b);
        logic [VPropWidth:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[VPropWidth] ? {VPropWidth{1'b1}} : sum[VPropWidth-1:0];
    endfunction

endpackage

// File: rtl/mgu_lane_select.sv
// Combinational extract of one edge element {dst, weight} from a buffered HBM line.
// Unweighted builds (WEIGHTED_EDGE_EN undefined) report a unit weight.
module mgu_lane_select
    import mgu_pkg::*;
(
    input  logic [DataWidth-1:0]  line_i,
    input  logic [LaneWidth-1:0]  lane_i,
    output logic [DstWidth-1:0]   dst_c_o,
    output logic [VPropWidth-1:0] weight_c_o
);

    logic [EdgeWidth-1:0] lanes [Epl];
    logic [EdgeWidth-1:0] elem_c;

    for (genvar g = 0; g < Epl; g++) begin : g_lane
        assign lanes[g] = line_i[g*EdgeWidth +: EdgeWidth];
    end

    assign elem_c  = lanes[lane_i];
    assign dst_c_o = elem_c[DstWidth-1:0];

`ifdef WEIGHTED_EDGE_EN
    assign weight_c_o = elem_c[EdgeWidth-1 -: VPropWidth];
`else
    assign weight_c_o = VPropWidth'(1);
`endif

endmodule

// File: rtl/mgu_edge_scatter.sv
// Message generation unit: walks an activated vertex's edge list and emits one update per edge.
// WEIGHTED_EDGE_EN selects weighted 64-bit edges; the default build handles 32-bit unweighted edges.
module mgu_edge_scatter
    import mgu_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [MgudWidth-1:0]   MGU_data,
    input  logic                   MGU_ready,
    output logic                   MGU_resp,
    output logic [AddrWidth-1:0]   read_addr,
    output logic                   start_rd,
    input  logic [DataWidth-1:0]   read_data,
    input  logic                   end_rd,
    output logic [UpdateWidth-1:0] update,
    output logic                   update_ready,
    input  logic                   update_resp,
    output logic                   busy
);

    state_e                  state_q, state_d;
    logic [VPropWidth-1:0]   prop_q, prop_d;
    logic [EIndexWidth-1:0]  rec_idx_q, rec_idx_d;
    logic [EDegreeWidth-1:0] rec_deg_q, rec_deg_d;
    logic [EIndexWidth-1:0]  idx_q, idx_d;
    logic [EDegreeWidth-1:0] rem_q, rem_d;
    logic [DataWidth-1:0]    line_q, line_d;
    logic                    resp_q, resp_d;
    logic [AddrWidth-1:0]    rd_addr_q, rd_addr_d;
    logic                    start_q, start_d;
    update_t                 upd_q, upd_d;
    logic                    upd_vld_q, upd_vld_d;
    logic                    busy_q, busy_d;

    mgu_rec_t                rec_in;
    logic                    unused_spare;
    logic [DstWidth-1:0]     dst_c;
    logic [VPropWidth-1:0]   weight_c;

    assign rec_in       = MGU_data;
    assign unused_spare = rec_in.spare;

    mgu_lane_select u_lane_select (
        .line_i     (line_q),
        .lane_i     (idx_q[LaneWidth-1:0]),
        .dst_c_o    (dst_c),
        .weight_c_o (weight_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        prop_d    = prop_q;
        rec_idx_d = rec_idx_q;
        rec_deg_d = rec_deg_q;
        idx_d     = idx_q;
        rem_d     = rem_q;
        line_d    = line_q;
        resp_d    = 1'b0;
        rd_addr_d = rd_addr_q;
        start_d   = 1'b0;
        upd_d     = upd_q;
        upd_vld_d = upd_vld_q;

        unique case (state_q)
            S_IDLE: begin
                if (MGU_ready) begin
                    prop_d    = rec_in.prop;
                    rec_idx_d = rec_in.edge_index;
                    rec_deg_d = rec_in.edge_degree;
                    resp_d    = 1'b1;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                rem_d   = rec_deg_q;
                idx_d   = rec_idx_q;
                state_d = (rec_deg_q == '0) ? S_IDLE : S_READ;
            end
            S_READ: begin
                rd_addr_d = EdgeBase + AddrWidth'({idx_q >> LaneWidth, {LineShift{1'b0}}});
                start_d   = 1'b1;
                state_d   = S_READ_WAIT;
            end
            S_READ_WAIT: begin
                if (end_rd) begin
                    line_d  = read_data;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                upd_d.addr  = VertexBase + (AddrWidth'(dst_c) << VertexShift);
                upd_d.value = sat_add(prop_q, weight_c);
                upd_vld_d   = 1'b1;
                state_d     = S_EMIT_ACK;
            end
            S_EMIT_ACK: begin
                if (update_resp) begin
                    upd_vld_d = 1'b0;
                    rem_d     = rem_q - EDegreeWidth'(1);
                    idx_d     = idx_q + EIndexWidth'(1);
                    state_d   = S_EMIT_REL;
                end
            end
            S_EMIT_REL: begin
                // Four-phase release; a fresh line is fetched only when idx crosses into it.
                if (!update_resp) begin
                    if (rem_q == '0) begin
                        state_d = S_IDLE;
                    end else if (idx_q[LaneWidth-1:0] == '0) begin
                        state_d = S_READ;
                    end else begin
                        state_d = S_EMIT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            prop_q    <= '0;
            rec_idx_q <= '0;
            rec_deg_q <= '0;
            idx_q     <= '0;
            rem_q     <= '0;
            line_q    <= '0;
            resp_q    <= 1'b0;
            rd_addr_q <= '0;
            start_q   <= 1'b0;
            upd_q     <= '0;
            upd_vld_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prop_q    <= prop_d;
            rec_idx_q <= rec_idx_d;
            rec_deg_q <= rec_deg_d;
            idx_q     <= idx_d;
            rem_q     <= rem_d;
            line_q    <= line_d;
            resp_q    <= resp_d;
            rd_addr_q <= rd_addr_d;
            start_q   <= start_d;
            upd_q     <= upd_d;
            upd_vld_q <= upd_vld_d;
            busy_q    <= busy_d;
        end
    end

    assign MGU_resp     = resp_q;
    assign read_addr    = rd_addr_q;
    assign start_rd     = start_q;
    assign update       = upd_q;
    assign update_ready = upd_vld_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_mgu_edge_scatter.sv
// Self-checking bench for mgu_edge_scatter: edge-list memory, four-phase receiver and a record-level model.
module tb_mgu_edge_scatter;

`ifdef WEIGHTED_EDGE_EN
    localparam bit TB_W = 1'b1;
`else
    localparam bit TB_W = 1'b0;
`endif
    localparam int unsigned TB_EPL = TB_W ? 4 : 8;
    localparam int unsigned TB_EW  = TB_W ? 64 : 32;
    localparam logic [32:0] TB_EBASE = 33'h1_0000_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic [96:0]   MGU_data;
    logic          MGU_ready;
    logic          MGU_resp;
    logic [32:0]   read_addr;
    logic          start_rd;
    logic [255:0]  read_data = '0;
    logic          end_rd = 1'b0;
    logic [64:0]   update;
    logic          update_ready;
    logic          update_resp = 1'b0;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [32:0] exp_rd_q[$];
    logic [64:0] exp_upd_q[$];
    logic [32:0] obs_rd_q[$];
    logic [64:0] obs_upd_q[$];

    mgu_edge_scatter dut (
        .clk          (clk),
        .reset        (reset),
        .MGU_data     (MGU_data),
        .MGU_ready    (MGU_ready),
        .MGU_resp     (MGU_resp),
        .read_addr    (read_addr),
        .start_rd     (start_rd),
        .read_data    (read_data),
        .end_rd       (end_rd),
        .update       (update),
        .update_ready (update_ready),
        .update_resp  (update_resp),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Edge element e holds destination 10+e and (weighted) weight (e%4)+1.
    function automatic logic [31:0] dst_of(input logic [31:0] e);
        return e + 32'd10;
    endfunction

    function automatic logic [31:0] wt_of(input logic [31:0] e);
        return (e % 32'd4) + 32'd1;
    endfunction

    function automatic logic [32:0] line_addr(input logic [31:0] e);
        return 33'(64'h1_0000_0000 + 64'(e / TB_EPL) * 64'd32);
    endfunction

    function automatic logic [255:0] mem_line(input logic [32:0] a);
        logic [255:0]    d;
        longint unsigned l;
        logic [31:0]     e;
        logic [63:0]     w;
        d = '0;
        l = (64'(a) - 64'h1_0000_0000) >> 5;
        for (int k = 0; k < int'(TB_EPL); k++) begin
            e = 32'(l * 64'(TB_EPL) + 64'(k));
            w = TB_W ? {wt_of(e), dst_of(e)} : {32'd0, dst_of(e)};
            d = d | (256'(w) << (k * int'(TB_EW)));
        end
        return d;
    endfunction

    // Expected reads and updates for one record, straight from the edge-walk rules.
    task automatic model_record(input logic [31:0] prop, input logic [31:0] idx, input logic [31:0] deg);
        logic [31:0]     e;
        longint unsigned v;
        for (longint unsigned i = 0; i < 64'(deg); i++) begin
            e = idx + 32'(i);
            if (i == 0 || (e % TB_EPL) == 0) exp_rd_q.push_back(line_addr(e));
            v = 64'(prop) + 64'(TB_W ? wt_of(e) : 32'd1);
            if (v > 64'hFFFF_FFFF) v = 64'hFFFF_FFFF;
            exp_upd_q.push_back({33'(64'(dst_of(e)) * 64'd32), 32'(v)});
        end
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Edge memory: answers each start_rd after rd_lat cycles.
    int          rd_lat = 2;
    int          rd_cnt = 0;
    logic [32:0] rd_addr_l = '0;
    always @(negedge clk) begin
        end_rd = 1'b0;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                end_rd    = 1'b1;
                read_data = mem_line(rd_addr_l);
            end
        end
        if (start_rd) begin
            rd_cnt    = rd_lat;
            rd_addr_l = read_addr;
        end
    end

    // Four-phase receiver: ack after rx_delay cycles, hold at least rx_hold cycles.
    int rx_delay = 0;
    int rx_hold  = 1;
    int rx_wait  = 0;
    int rx_left  = 0;
    always @(negedge clk) begin
        if (reset) begin
            update_resp = 1'b0;
            rx_wait     = 0;
            rx_left     = 0;
        end else if (update_resp) begin
            if (rx_left > 1) rx_left--;
            else if (!update_ready) update_resp = 1'b0;
        end else if (update_ready) begin
            if (rx_wait >= rx_delay) begin
                update_resp = 1'b1;
                rx_left     = rx_hold;
                rx_wait     = 0;
            end else begin
                rx_wait++;
            end
        end
    end

    // Compare process: reads and messages against the model, plus pulse/stability rules.
    logic        start_prev = 1'b0;
    logic        upd_prev   = 1'b0;
    logic [64:0] upd_hold   = '0;
    always @(negedge clk) begin
        logic [64:0] eu;
        logic [32:0] er;
        if (start_rd) begin
            obs_rd_q.push_back(read_addr);
            n_tests++;
            if (exp_rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL read_unexpected: got addr %0h expected no read", read_addr);
            end else begin
                er = exp_rd_q.pop_front();
                if (read_addr !== er) begin
                    n_fail++;
                    $display("FAIL read_addr: got %0h expected %0h", read_addr, er);
                end
            end
            check("start_rd_one_cycle", 128'(start_prev), 128'(0));
        end
        if (update_ready && !upd_prev) begin
            obs_upd_q.push_back(update);
            n_tests++;
            if (exp_upd_q.size() == 0) begin
                n_fail++;
                $display("FAIL update_unexpected: got %0h expected no message", update);
            end else begin
                eu = exp_upd_q.pop_front();
                if (update !== eu) begin
                    n_fail++;
                    $display("FAIL update_msg: got %0h expected %0h", update, eu);
                end
            end
        end else if (update_ready && upd_prev) begin
            check("update_stable", 128'(update), 128'(upd_hold));
        end
        start_prev = start_rd;
        upd_prev   = update_ready;
        upd_hold   = update;
    end

    task automatic send_record(input logic [31:0] prop, input logic [31:0] idx, input logic [31:0] deg);
        bit got;
        got       = 1'b0;
        MGU_data  = {1'b1, prop, idx, deg};
        MGU_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (MGU_resp) begin
                got = 1'b1;
                break;
            end
        end
        check("mgu_resp_seen", 128'(got), 128'(1));
        MGU_ready = 1'b0;
        @(negedge clk);
        check("mgu_resp_pulse", 128'(MGU_resp), 128'(0));
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!busy) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({name, "_idle"}, 128'(done), 128'(1));
        check({name, "_rd_left"}, 128'(exp_rd_q.size()), 128'(0));
        check({name, "_upd_left"}, 128'(exp_upd_q.size()), 128'(0));
        check({name, "_rdy_low"}, 128'(update_ready), 128'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  nr;
        int  nu;
        bit  got;
        reset     = 1'b1;
        MGU_ready = 1'b0;
        MGU_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_resp", 128'(MGU_resp), 128'(0));
        check("rst_start", 128'(start_rd), 128'(0));
        check("rst_rdy", 128'(update_ready), 128'(0));
        check("rst_addr", 128'(read_addr), 128'(0));
        check("rst_update", 128'(update), 128'(0));
        reset = 1'b0;
        @(negedge clk);

        // One line, lanes 5..7.
        nr = obs_rd_q.size(); nu = obs_upd_q.size();
        model_record(32'd7, 32'd5, 32'd3);
        send_record(32'd7, 32'd5, 32'd3);
        wait_idle("t1");
        check("t1_nrd", 128'(obs_rd_q.size() - nr), 128'(1));
        check("t1_rd0", 128'(obs_rd_q[nr]), 128'(TB_W ? 33'h1_0000_0020 : 33'h1_0000_0000));
        check("t1_u0", 128'(obs_upd_q[nu]),   128'({33'h1E0, TB_W ? 32'd9 : 32'd8}));
        check("t1_u1", 128'(obs_upd_q[nu+1]), 128'({33'h200, TB_W ? 32'd10 : 32'd8}));
        check("t1_u2", 128'(obs_upd_q[nu+2]), 128'({33'h220, TB_W ? 32'd11 : 32'd8}));

        // Line crossing.
        nr = obs_rd_q.size(); nu = obs_upd_q.size();
        model_record(32'd100, 32'd6, 32'd4);
        send_record(32'd100, 32'd6, 32'd4);
        wait_idle("t2");
        check("t2_nrd", 128'(obs_rd_q.size() - nr), 128'(2));
        check("t2_rd0", 128'(obs_rd_q[nr]),   128'(TB_W ? 33'h1_0000_0020 : 33'h1_0000_0000));
        check("t2_rd1", 128'(obs_rd_q[nr+1]), 128'(TB_W ? 33'h1_0000_0040 : 33'h1_0000_0020));
        check("t2_u0", 128'(obs_upd_q[nu]),   128'({33'h200, TB_W ? 32'd103 : 32'd101}));
        check("t2_u2", 128'(obs_upd_q[nu+2]), 128'({33'h240, TB_W ? 32'd101 : 32'd101}));

        // Zero degree: accepted, no traffic, idle two cycles after accept.
        nr = obs_rd_q.size(); nu = obs_upd_q.size();
        send_record(32'd9, 32'd3, 32'd0);
        check("t3_busy", 128'(busy), 128'(0));
        repeat (4) @(negedge clk);
        check("t3_nrd", 128'(obs_rd_q.size() - nr), 128'(0));
        check("t3_nupd", 128'(obs_upd_q.size() - nu), 128'(0));

        // Saturation.
        nu = obs_upd_q.size();
        model_record(32'hFFFF_FFFF, 32'd0, 32'd2);
        send_record(32'hFFFF_FFFF, 32'd0, 32'd2);
        wait_idle("t4");
        check("t4_u0", 128'(obs_upd_q[nu]),   128'({33'h140, 32'hFFFF_FFFF}));
        check("t4_u1", 128'(obs_upd_q[nu+1]), 128'({33'h160, 32'hFFFF_FFFF}));

        // Weight 3 on element 2.
        nu = obs_upd_q.size();
        model_record(32'd5, 32'd2, 32'd1);
        send_record(32'd5, 32'd2, 32'd1);
        wait_idle("t5");
        check("t5_u0", 128'(obs_upd_q[nu]), 128'({33'h180, TB_W ? 32'd8 : 32'd6}));

        // Slow receiver: late ack held two cycles.
        rx_delay = 10; rx_hold = 2;
        nu = obs_upd_q.size();
        model_record(32'd1, 32'd9, 32'd3);
        send_record(32'd1, 32'd9, 32'd3);
        wait_idle("t6");
        check("t6_nupd", 128'(obs_upd_q.size() - nu), 128'(3));
        check("t6_u0", 128'(obs_upd_q[nu]), 128'({33'h260, TB_W ? 32'd3 : 32'd2}));
        rx_delay = 0; rx_hold = 1;

        // Reset while waiting on the read; the late end_rd must be ignored.
        rd_lat = 1;
        nu = obs_upd_q.size();
        exp_rd_q.push_back(TB_EBASE);
        send_record(32'd3, 32'd0, 32'd4);
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (start_rd) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t7_start_seen", 128'(got), 128'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t7_busy", 128'(busy), 128'(0));
        check("t7_start", 128'(start_rd), 128'(0));
        check("t7_rdy", 128'(update_ready), 128'(0));
        check("t7_addr", 128'(read_addr), 128'(0));
        check("t7_update", 128'(update), 128'(0));
        repeat (6) @(negedge clk);
        check("t7_nupd", 128'(obs_upd_q.size() - nu), 128'(0));
        check("t7_busy_late", 128'(busy), 128'(0));
        check("t7_rd_left", 128'(exp_rd_q.size()), 128'(0));
        rd_lat = 2;

        // Normal record after the abandoned one.
        nr = obs_rd_q.size(); nu = obs_upd_q.size();
        model_record(32'd50, 32'd20, 32'd5);
        send_record(32'd50, 32'd20, 32'd5);
        wait_idle("t8");
        check("t8_nrd", 128'(obs_rd_q.size() - nr), 128'(2));
        check("t8_nupd", 128'(obs_upd_q.size() - nu), 128'(5));

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
